// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO holding a true DEPTH entries.
// It supports a registered-read or first-word-fall-through output.
// It reports occupancy, almost-full/almost-empty levels and sticky error flags,
// and provides a synchronous flush.
module sync_fifo_param #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clr,
  input  logic                         enq,
  input  logic                         deq,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags derive straight from the occupancy counter.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  // A flush suppresses both the write and the read.
  assign wr_ok = enq & (~full | deq) & ~clr;
  assign rd_ok = deq & ~empty & ~clr;

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[w_ptr] <= data_in;
  end

  // Pointer, occupancy and sticky error state; flush has priority over traffic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= next_ptr(w_ptr);
      if (rd_ok) r_ptr <= next_ptr(r_ptr);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (enq & full & ~deq) overflow <= 1'b1;
      if (deq & empty)       underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is shown whenever data is held; an empty FIFO shows zero.
      assign data_out = empty ? '0 : mem[r_ptr];
    end else begin : g_reg
      // Registered read: the head entry is captured on an accepted read and otherwise held.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) data_out <= '0;
        else if (rd_ok) data_out <= mem[r_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives two FIFO configurations (DEPTH=8 registered, DEPTH=5 FWFT)
// with shared directed and random traffic and scoreboards both against a queue model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clr;
  logic       enq;
  logic       deq;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] count0;
  logic [2:0] count1;

  typedef struct {
    int cnt;
    bit full;
    bit empty;
    bit af;
    bit ae;
    bit ovf;
    bit udf;
    int dout;
  } exp_t;

  exp_t       exp_q0[$];
  exp_t       exp_q1[$];
  logic [7:0] model_q[2][$];
  int         depth_m[2] = '{8, 5};
  int         af_m[2]    = '{7, 4};
  bit         fwft_m[2]  = '{1'b0, 1'b1};
  bit         ovf_m[2];
  bit         udf_m[2];
  int         dreg_m[2];
  int         checks = 0;
  int         passes = 0;

  sync_fifo_param #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) dut0 (
    .clk(clk), .resetn(resetn), .clr(clr), .enq(enq), .deq(deq), .data_in(data_in),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(.DEPTH(5), .DATA_WIDTH(8), .FWFT(1)) dut1 (
    .clk(clk), .resetn(resetn), .clr(clr), .enq(enq), .deq(deq), .data_in(data_in),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  always #5 clk = ~clk;

  // Expected visible state of one FIFO, derived from its model queue.
  function automatic exp_t snapshot(int id);
    exp_t e;
    e.cnt   = model_q[id].size();
    e.full  = (e.cnt == depth_m[id]);
    e.empty = (e.cnt == 0);
    e.af    = (e.cnt >= af_m[id]);
    e.ae    = (e.cnt <= 1);
    e.ovf   = ovf_m[id];
    e.udf   = udf_m[id];
    if (fwft_m[id]) e.dout = (e.cnt != 0) ? int'(model_q[id][0]) : 0;
    else            e.dout = dreg_m[id];
    return e;
  endfunction

  // Behavioural FIFO: a plain queue with drop rules for full/empty and a flush.
  task automatic modelStep(int id, bit e, bit d, logic [7:0] din, bit c);
    int  n;
    bit  rd;
    bit  wr;
    n = model_q[id].size();
    if (c) begin
      model_q[id].delete();
      ovf_m[id] = 1'b0;
      udf_m[id] = 1'b0;
    end else begin
      rd = d && (n != 0);
      wr = e && ((n != depth_m[id]) || d);
      if (e && (n == depth_m[id]) && !d) ovf_m[id] = 1'b1;
      if (d && (n == 0)) udf_m[id] = 1'b1;
      if (rd) dreg_m[id] = int'(model_q[id].pop_front());
      if (wr) model_q[id].push_back(din);
    end
  endtask

  task automatic modelReset();
    for (int id = 0; id < 2; id++) begin
      model_q[id].delete();
      ovf_m[id]  = 1'b0;
      udf_m[id]  = 1'b0;
      dreg_m[id] = 0;
    end
  endtask

  task automatic checkOutput(string name, int act, int expv);
    checks++;
    if (act == expv) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // One clock of traffic: drive at the falling edge and queue the expected post-edge state.
  task automatic applyStimulus(bit e, bit d, logic [7:0] din, bit c);
    @(negedge clk);
    enq     = e;
    deq     = d;
    data_in = din;
    clr     = c;
    modelStep(0, e, d, din, c);
    modelStep(1, e, d, din, c);
    exp_q0.push_back(snapshot(0));
    exp_q1.push_back(snapshot(1));
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, "_count0"}, int'(count0), 0);
    checkOutput({tag, "_count1"}, int'(count1), 0);
    checkOutput({tag, "_dout0"}, int'(dout0), 0);
    checkOutput({tag, "_dout1"}, int'(dout1), 0);
    checkOutput({tag, "_empty0"}, int'(empty0), 1);
    checkOutput({tag, "_empty1"}, int'(empty1), 1);
    checkOutput({tag, "_ovf0"}, int'(ovf0), 0);
    checkOutput({tag, "_ovf1"}, int'(ovf1), 0);
    checkOutput({tag, "_udf0"}, int'(udf0), 0);
    checkOutput({tag, "_udf1"}, int'(udf1), 0);
  endtask

  // Monitor: after each rising edge, pop the expected state and compare every output.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      checkOutput("d8_count", int'(count0), e.cnt);
      checkOutput("d8_full", int'(full0), int'(e.full));
      checkOutput("d8_empty", int'(empty0), int'(e.empty));
      checkOutput("d8_almost_full", int'(af0), int'(e.af));
      checkOutput("d8_almost_empty", int'(ae0), int'(e.ae));
      checkOutput("d8_overflow", int'(ovf0), int'(e.ovf));
      checkOutput("d8_underflow", int'(udf0), int'(e.udf));
      checkOutput("d8_data_out", int'(dout0), e.dout);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      checkOutput("d5_count", int'(count1), e.cnt);
      checkOutput("d5_full", int'(full1), int'(e.full));
      checkOutput("d5_empty", int'(empty1), int'(e.empty));
      checkOutput("d5_almost_full", int'(af1), int'(e.af));
      checkOutput("d5_almost_empty", int'(ae1), int'(e.ae));
      checkOutput("d5_overflow", int'(ovf1), int'(e.ovf));
      checkOutput("d5_underflow", int'(udf1), int'(e.udf));
      checkOutput("d5_data_out", int'(dout1), e.dout);
    end
  end

  // Directed scenarios followed by random traffic and an asynchronous reset mid-burst.
  initial begin
    resetn  = 1'b0;
    clr     = 1'b0;
    enq     = 1'b0;
    deq     = 1'b0;
    data_in = 8'h00;
    modelReset();
    #12;
    checkResetState("reset");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h11 * i), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    applyStimulus(1'b1, 1'b0, 8'hA1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hB2, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hC3, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h40, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h41, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h42 + i), 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 39) == 0));
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 8'(8'hE0 + i), 1'b0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    enq    = 1'b0;
    deq    = 1'b0;
    #1;
    checkResetState("async_reset");
    modelReset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'hC4, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
